// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file for the 5-stage MIPS pipeline.
// Picks the write-back value, commits it on the clock edge, and serves two bypassed read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] link_addr_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_en_o,
  output logic [CNT_W-1:0]  write_count_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:NREG-1];
  logic [CNT_W-1:0]  write_count;

  // Jump outranks memToReg so a linking jump always writes PC+8.
  always_comb begin
    wb_data_o = alu_result_i;
    if (jump_i)
      wb_data_o = link_addr_i;
    else if (mem_to_reg_i)
      wb_data_o = read_data_i;
  end

  assign wb_en_o = reg_write_i && (write_reg_i != '0);

  // Entry 0 is reset and never written, so it stays zero without special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs        <= '{default: '0};
      write_count <= '0;
    end else if (wb_en_o) begin
      regs[write_reg_i] <= wb_data_o;
      if (write_count != '1)
        write_count <= write_count + CNT_W'(1);
    end
  end

  assign write_count_o = write_count;

  // Same-cycle write-through; address 0 is forced to zero ahead of any bypass match.
  always_comb begin
    rs_data_o = '0;
    if (rs_addr_i != '0)
      rs_data_o = (wb_en_o && (rs_addr_i == write_reg_i)) ? wb_data_o : regs[rs_addr_i];
  end

  always_comb begin
    rt_data_o = '0;
    if (rt_addr_i != '0)
      rt_data_o = (wb_en_o && (rt_addr_i == write_reg_i)) ? wb_data_o : regs[rt_addr_i];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, mux priority, $0 protection, bypass and counter saturation.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump, mem_to_reg, reg_write;
  logic [31:0] read_data, alu_result, link_addr;
  logic [4:0]  write_reg, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [31:0] write_count;
  logic [31:0] s_rs, s_rt, s_wb;
  logic        s_en;
  logic [3:0]  s_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .jump_i(jump), .mem_to_reg_i(mem_to_reg),
    .reg_write_i(reg_write), .read_data_i(read_data), .alu_result_i(alu_result),
    .link_addr_i(link_addr), .write_reg_i(write_reg), .rs_addr_i(rs_addr),
    .rt_addr_i(rt_addr), .rs_data_o(rs_data), .rt_data_o(rt_data),
    .wb_data_o(wb_data), .wb_en_o(wb_en), .write_count_o(write_count)
  );

  wb_regfile #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .jump_i(jump), .mem_to_reg_i(mem_to_reg),
    .reg_write_i(reg_write), .read_data_i(read_data), .alu_result_i(alu_result),
    .link_addr_i(link_addr), .write_reg_i(write_reg), .rs_addr_i(rs_addr),
    .rt_addr_i(rt_addr), .rs_data_o(s_rs), .rt_data_o(s_rt),
    .wb_data_o(s_wb), .wb_en_o(s_en), .write_count_o(s_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge, well clear of the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; jump = 0; mem_to_reg = 0; reg_write = 0;
    read_data = '0; alu_result = '0; link_addr = '0;
    write_reg = '0; rs_addr = '0; rt_addr = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Populate a few registers, then hit reset mid-cycle with a write pending
    for (int i = 1; i <= 3; i++) begin
      reg_write = 1; write_reg = 5'(i); alu_result = 32'h100 + 32'(i);
      step();
    end
    write_reg = 3; alu_result = 32'hCAFE0003; rs_addr = 1; rt_addr = 2;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rs1_async", rs_data, 32'h0);
    check("rst_rt2_async", rt_data, 32'h0);
    check("rst_count_async", write_count, 32'h0);
    step();
    reg_write = 0;
    for (int a = 1; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a + 1);
      #1;
      check($sformatf("rst_rs%0d", a), rs_data, 32'h0);
      check($sformatf("rst_rt%0d", 31 - a + 1), rt_data, 32'h0);
    end
    check("rst_count_edge", write_count, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU write with same-cycle bypass
    reg_write = 1; write_reg = 8; alu_result = 32'h12345678; rs_addr = 8; rt_addr = 9;
    #1;
    check("alu_bypass", rs_data, 32'h12345678);
    check("alu_wb_en", {31'b0, wb_en}, 32'h1);
    check("alu_rt_nobypass", rt_data, 32'h0);
    step();
    reg_write = 0;
    #1;
    check("alu_stored", rs_data, 32'h12345678);
    check("alu_count", write_count, 32'd1);

    // Jump overrides memToReg
    reg_write = 1; jump = 1; mem_to_reg = 1; write_reg = 31;
    link_addr = 32'h00400008; read_data = 32'hDEADBEEF; rs_addr = 31;
    #1;
    check("mux_jump_wb", wb_data, 32'h00400008);
    step();
    reg_write = 0;
    #1;
    check("mux_jump_reg31", rs_data, 32'h00400008);
    reg_write = 1; jump = 0;
    #1;
    check("mux_load_wb", wb_data, 32'hDEADBEEF);
    step();
    reg_write = 0; mem_to_reg = 0;
    #1;
    check("mux_load_reg31", rs_data, 32'hDEADBEEF);
    check("mux_alu_wb", wb_data, 32'h12345678);
    check("mux_count", write_count, 32'd3);

    // Writes to $0 are dropped and not counted
    reg_write = 1; write_reg = 0; alu_result = 32'hFFFFFFFF; rs_addr = 0; rt_addr = 0;
    #1;
    check("r0_same_rs", rs_data, 32'h0);
    check("r0_same_rt", rt_data, 32'h0);
    check("r0_wb_en", {31'b0, wb_en}, 32'h0);
    step();
    reg_write = 0;
    #1;
    check("r0_next", rs_data, 32'h0);
    check("r0_count", write_count, 32'd3);

    // Both ports bypass together, then a disabled write must not disturb state
    reg_write = 1; write_reg = 5; alu_result = 32'hA5A5A5A5; rs_addr = 5; rt_addr = 5;
    #1;
    check("dual_rs", rs_data, 32'hA5A5A5A5);
    check("dual_rt", rt_data, 32'hA5A5A5A5);
    step();
    reg_write = 0; alu_result = 32'h11111111;
    #1;
    check("nowr_rs", rs_data, 32'hA5A5A5A5);
    check("nowr_rt", rt_data, 32'hA5A5A5A5);
    step();
    #1;
    check("nowr_rs_edge", rs_data, 32'hA5A5A5A5);
    check("nowr_count", write_count, 32'd4);
    check("sat_count_start", {28'b0, s_count}, 32'd4);

    // 20 further writes: 4-bit counter saturates at 4'hF, 32-bit counter keeps going
    rs_addr = 9; rt_addr = 8;
    for (int k = 1; k <= 20; k++) begin
      reg_write = 1; write_reg = 9; alu_result = 32'h9000 + 32'(k);
      step();
      if (k == 10) check("sat_count_14", {28'b0, s_count}, 32'hE);
    end
    reg_write = 0;
    #1;
    check("sat_count_hold", {28'b0, s_count}, 32'hF);
    check("main_count_24", write_count, 32'd24);
    check("loop_reg9", rs_data, 32'h9014);
    check("loop_reg8_kept", rt_data, 32'h12345678);
    step();
    check("sat_count_idle", {28'b0, s_count}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
